lc3_control: RTL

Microsequencing control unit for the LC-3 datapath. It drives every datapath control line: bus tri-state enables, register/flag/IR/PC/MAR/MDR load strobes, mux selects, ALU operation, register-file addresses and memory write. It sequences fetch, decode and execute for the supported LC-3 subset using the fed-back `IR` and `N`/`Z`/`P` flags. It sits beside the datapath in the LC-3 top level and is the only source of these control signals.

---
 rtl/lc3_control.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control.sv
// lc3_control: microsequencer for the LC-3 datapath subset.
// The state register advances on each rising clock edge.
// Every datapath control line is decoded combinationally from the current state
// (plus IR and the N/Z/P flags), and all of them are held at 0 while rst is high.
module lc3_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic        enaMARM,
    output logic        enaPC,
    output logic        enaMDR,
    output logic        enaALU,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        regWE,
    output logic        flagWE,
    output logic        memWE,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMAR,
    output logic        selMDR,
    output logic [1:0]  ALUctrl,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic        halt
);

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_OPR    = 4'd4,
        S_BR     = 4'd5,
        S_JMP    = 4'd6,
        S_LEA    = 4'd7,
        S_LD1    = 4'd8,
        S_LD2    = 4'd9,
        S_LD3    = 4'd10,
        S_ST1    = 4'd11,
        S_ST2    = 4'd12,
        S_ST3    = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    // Bundle of every control output, in port order.
    typedef struct packed {
        logic       enaMARM;
        logic       enaPC;
        logic       enaMDR;
        logic       enaALU;
        logic       ldPC;
        logic       ldIR;
        logic       ldMAR;
        logic       ldMDR;
        logic       regWE;
        logic       flagWE;
        logic       memWE;
        logic [1:0] selPC;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic       selMAR;
        logic       selMDR;
        logic [1:0] ALUctrl;
        logic [2:0] DR;
        logic [2:0] SR1;
        logic [2:0] SR2;
        logic       halt;
    } ctl_t;

    state_t     state_q;
    state_t     state_d;
    ctl_t       ctl_s;
    logic [3:0] opcode_s;
    logic       base_reg_s;  // LDR/STR: base register + offset6 addressing
    logic       unused_s;

    assign opcode_s   = IR[15:12];
    assign base_reg_s = (opcode_s == 4'b0110) || (opcode_s == 4'b0111);
    assign unused_s   = ^IR[5:3];

    // State register; reset lands in FETCH0 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode for the current state.
    always_comb begin
        state_d   = state_q;
        ctl_s     = {$bits(ctl_t){1'b0}};
        ctl_s.DR  = IR[11:9];
        ctl_s.SR1 = IR[8:6];
        ctl_s.SR2 = IR[2:0];
        case (state_q)
            S_FETCH0: begin
                ctl_s.enaPC = 1'b1;
                ctl_s.ldMAR = 1'b1;
                ctl_s.ldPC  = 1'b1;
                ctl_s.selPC = 2'b00;
                state_d     = S_FETCH1;
            end
            S_FETCH1: begin
                ctl_s.ldMDR  = 1'b1;
                ctl_s.selMDR = 1'b1;
                state_d      = S_FETCH2;
            end
            S_FETCH2: begin
                ctl_s.enaMDR = 1'b1;
                ctl_s.ldIR   = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_s)
                    4'b0001, 4'b0101, 4'b1001: state_d = S_OPR;
                    4'b0000:                   state_d = S_BR;
                    4'b1100:                   state_d = S_JMP;
                    4'b1110:                   state_d = S_LEA;
                    4'b0010, 4'b0110:          state_d = S_LD1;
                    4'b0011, 4'b0111:          state_d = S_ST1;
                    4'b1101:                   state_d = S_HALT;
                    default:                   state_d = S_FETCH0;  // unimplemented: NOP
                endcase
            end
            S_OPR: begin
                ctl_s.enaALU = 1'b1;
                ctl_s.regWE  = 1'b1;
                ctl_s.flagWE = 1'b1;
                case (opcode_s)
                    4'b0101: ctl_s.ALUctrl = 2'b01;
                    4'b1001: ctl_s.ALUctrl = 2'b10;
                    default: ctl_s.ALUctrl = 2'b00;
                endcase
                state_d = S_FETCH0;
            end
            S_BR: begin
                ctl_s.selEAB1 = 1'b0;
                ctl_s.selEAB2 = 2'b10;
                ctl_s.selPC   = 2'b01;
                ctl_s.ldPC    = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
                state_d       = S_FETCH0;
            end
            S_JMP: begin
                ctl_s.ldPC    = 1'b1;
                ctl_s.selPC   = 2'b01;
                ctl_s.selEAB1 = 1'b1;
                ctl_s.selEAB2 = 2'b00;
                state_d       = S_FETCH0;
            end
            S_LEA: begin
                ctl_s.enaMARM = 1'b1;
                ctl_s.selMAR  = 1'b0;
                ctl_s.selEAB1 = 1'b0;
                ctl_s.selEAB2 = 2'b10;
                ctl_s.regWE   = 1'b1;
                state_d       = S_FETCH0;
            end
            S_LD1, S_ST1: begin
                ctl_s.enaMARM = 1'b1;
                ctl_s.ldMAR   = 1'b1;
                ctl_s.selMAR  = 1'b0;
                if (base_reg_s) begin
                    ctl_s.selEAB1 = 1'b1;
                    ctl_s.selEAB2 = 2'b01;
                end else begin
                    ctl_s.selEAB1 = 1'b0;
                    ctl_s.selEAB2 = 2'b10;
                end
                state_d = (state_q == S_LD1) ? S_LD2 : S_ST2;
            end
            S_LD2: begin
                ctl_s.ldMDR  = 1'b1;
                ctl_s.selMDR = 1'b1;
                state_d      = S_LD3;
            end
            S_LD3: begin
                ctl_s.enaMDR = 1'b1;
                ctl_s.regWE  = 1'b1;
                ctl_s.flagWE = 1'b1;
                state_d      = S_FETCH0;
            end
            S_ST2: begin
                // Source register sits in the DR field for stores; pass it through the ALU.
                ctl_s.SR1     = IR[11:9];
                ctl_s.ALUctrl = 2'b11;
                ctl_s.enaALU  = 1'b1;
                ctl_s.ldMDR   = 1'b1;
                ctl_s.selMDR  = 1'b0;
                state_d       = S_ST3;
            end
            S_ST3: begin
                ctl_s.memWE = 1'b1;
                state_d     = S_FETCH0;
            end
            S_HALT: begin
                ctl_s.halt = 1'b1;
                state_d    = S_HALT;
            end
            default: begin
                state_d = S_FETCH0;
            end
        endcase
    end

    // Reset forces every control line low, overriding the FETCH0 decode.
    assign {enaMARM, enaPC, enaMDR, enaALU, ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE,
            memWE, selPC, selEAB1, selEAB2, selMAR, selMDR, ALUctrl, DR, SR1, SR2, halt}
        = rst ? {$bits(ctl_t){1'b0}} : ctl_s;

endmodule
